// File: rtl/pixel_scheduler.sv
// pixel_scheduler
// Walks the frame in raster order, issuing one fixed-point screen coordinate
// pair per cycle into the ray pipeline, and turns the pipeline's in-order
// results into framebuffer writes tagged with their linear pixel address.
// A credit count bounds the rays in flight; done fires only once every
// issued ray has come back.
module pixel_scheduler #(
    parameter int                      WIDTH        = 640,
    parameter int                      HEIGHT       = 480,
    parameter int                      FP_W         = 32,
    parameter int                      FRAC         = 16,
    // Roughly 1/240 in Q(FP_W-FRAC).FRAC; 0x111 for the default FRAC of 16
    parameter logic signed [FP_W-1:0]  STEP         = FP_W'((1 << FRAC) / 240),
    parameter int                      MAX_INFLIGHT = 64,
    parameter int                      ADDR_W       = $clog2(WIDTH * HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic                   ray_valid,
    output logic signed [FP_W-1:0] screen_x,
    output logic signed [FP_W-1:0] screen_y,
    input  logic                   res_valid,
    input  logic                   res_hit,
    output logic                   pix_we,
    output logic [ADDR_W-1:0]      pix_addr,
    output logic                   pix_hit
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int CW    = $clog2(MAX_INFLIGHT + 1);
    // One extra bit so the retired count can reach TOTAL itself
    localparam int RW    = ADDR_W + 1;

    // Row-start coordinates, fixed at elaboration so no multiplier is needed
    localparam logic signed [FP_W-1:0] HALF_W = FP_W'(WIDTH / 2);
    localparam logic signed [FP_W-1:0] HALF_H = FP_W'(HEIGHT / 2);
    localparam logic signed [FP_W-1:0] ROW_X0 = -(HALF_W * STEP);
    localparam logic signed [FP_W-1:0] COL_Y0 = HALF_H * STEP;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [XW-1:0]          x_cnt_q, x_cnt_d;
    logic [YW-1:0]          y_cnt_q, y_cnt_d;
    logic signed [FP_W-1:0] sx_q, sx_d;
    logic signed [FP_W-1:0] sy_q, sy_d;
    logic [CW-1:0]          inflight_q, inflight_d;
    logic [RW-1:0]          ret_cnt_q, ret_cnt_d;

    logic                   ray_valid_q;
    logic signed [FP_W-1:0] screen_x_q, screen_y_q;
    logic                   pix_we_q, pix_hit_q;
    logic [ADDR_W-1:0]      pix_addr_q;

    logic issue, retire, last_x, last_pix;

    // Decide this cycle's issue and retire from the registered credit count
    always_comb begin
        issue    = (state_q == S_ISSUE) && !stall && (inflight_q < CW'(MAX_INFLIGHT));
        // A result with nothing in flight is a protocol error and is dropped
        retire   = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && res_valid &&
                   (inflight_q != '0);
        last_x   = (x_cnt_q == XW'(WIDTH - 1));
        last_pix = last_x && (y_cnt_q == YW'(HEIGHT - 1));
    end

    // Next state of the frame FSM, raster walk, coordinates and credits
    always_comb begin
        state_d    = state_q;
        x_cnt_d    = x_cnt_q;
        y_cnt_d    = y_cnt_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        inflight_d = inflight_q;
        ret_cnt_d  = ret_cnt_q;

        // Simultaneous issue and retire cancel out
        if (issue && !retire) begin
            inflight_d = inflight_q + CW'(1);
        end else if (retire && !issue) begin
            inflight_d = inflight_q - CW'(1);
        end
        if (retire) begin
            ret_cnt_d = ret_cnt_q + RW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_cnt_d    = '0;
                    y_cnt_d    = '0;
                    sx_d       = ROW_X0;
                    sy_d       = COL_Y0;
                    inflight_d = '0;
                    ret_cnt_d  = '0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    if (last_x) begin
                        x_cnt_d = '0;
                        sx_d    = ROW_X0;
                        y_cnt_d = y_cnt_q + YW'(1);
                        sy_d    = sy_q - STEP;
                    end else begin
                        x_cnt_d = x_cnt_q + XW'(1);
                        sx_d    = sx_q + STEP;
                    end
                    if (last_pix) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((inflight_q == '0) && (ret_cnt_q == RW'(TOTAL))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame in progress
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            inflight_q  <= '0;
            ret_cnt_q   <= '0;
            ray_valid_q <= 1'b0;
            screen_x_q  <= '0;
            screen_y_q  <= '0;
            pix_we_q    <= 1'b0;
            pix_addr_q  <= '0;
            pix_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            inflight_q  <= inflight_d;
            ret_cnt_q   <= ret_cnt_d;
            ray_valid_q <= issue;
            if (issue) begin
                screen_x_q <= sx_q;
                screen_y_q <= sy_q;
            end
            pix_we_q <= retire;
            if (retire) begin
                pix_addr_q <= ret_cnt_q[ADDR_W-1:0];
                pix_hit_q  <= res_hit;
            end
        end
    end

    assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign ray_valid = ray_valid_q;
    assign screen_x  = screen_x_q;
    assign screen_y  = screen_y_q;
    assign pix_we    = pix_we_q;
    assign pix_addr  = pix_addr_q;
    assign pix_hit   = pix_hit_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Scoreboard bench for pixel_scheduler on a 4x2 frame with unit step.
// u_dut (4 credits) gets a result loopback; u_dut2 (2 credits) is driven
// by hand to probe credit exhaustion.
module tb_pixel_scheduler;

    localparam int W      = 4;
    localparam int H      = 2;
    localparam int N      = W * H;
    localparam int AW     = $clog2(N);
    localparam int STEP_I = 65536;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } coord_t;
    typedef struct {
        int   addr;
        logic hit;
    } wr_t;

    logic clk = 1'b0;
    logic rst, start, stall, res_valid, res_hit;
    logic busy, done, ray_valid, pix_we, pix_hit;
    logic signed [31:0] screen_x, screen_y;
    logic [AW-1:0] pix_addr;

    logic start2, stall2, res_valid2, res_hit2;
    logic busy2, done2, ray_valid2, pix_we2, pix_hit2;
    logic signed [31:0] screen_x2, screen_y2;
    logic [AW-1:0] pix_addr2;

    pixel_scheduler #(
        .WIDTH(W), .HEIGHT(H), .FP_W(32), .FRAC(16),
        .STEP(32'sh0001_0000), .MAX_INFLIGHT(4)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .busy(busy), .done(done), .ray_valid(ray_valid),
        .screen_x(screen_x), .screen_y(screen_y),
        .res_valid(res_valid), .res_hit(res_hit),
        .pix_we(pix_we), .pix_addr(pix_addr), .pix_hit(pix_hit)
    );

    pixel_scheduler #(
        .WIDTH(W), .HEIGHT(H), .FP_W(32), .FRAC(16),
        .STEP(32'sh0001_0000), .MAX_INFLIGHT(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .stall(stall2),
        .busy(busy2), .done(done2), .ray_valid(ray_valid2),
        .screen_x(screen_x2), .screen_y(screen_y2),
        .res_valid(res_valid2), .res_hit(res_hit2),
        .pix_we(pix_we2), .pix_addr(pix_addr2), .pix_hit(pix_hit2)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    coord_t cq[$];
    wr_t    wq[$];
    int     due[$];
    logic   hq2[$];
    int fed_cnt, lb_limit, res_idx, rays_f, fwrites, done_cnt, run, max_run, last_due;
    int r2, w2, sent2, done2_cnt;
    logic inj, lb_rand, prev_busy;
    coord_t c;
    wr_t    w;
    logic   hb;
    int     d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference coordinates straight from pixel index: x = (col - W/2)*step,
    // y = (H/2 - row)*step
    function automatic logic [31:0] exp_x(input int p);
        return 32'(((p % W) - W / 2) * STEP_I);
    endfunction
    function automatic logic [31:0] exp_y(input int p);
        return 32'((H / 2 - p / W) * STEP_I);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor both DUTs and drive the u_dut result loopback
    initial begin
        res_valid = 1'b0;
        res_hit   = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (ray_valid === 1'b1) begin
                chk("ray_expected", 64'(cq.size() != 0), 1);
                if (cq.size() != 0) begin
                    c = cq.pop_front();
                    chk("screen_x", 64'($unsigned(screen_x)), 64'(c.x));
                    chk("screen_y", 64'($unsigned(screen_y)), 64'(c.y));
                end
                rays_f++;
                run++;
                if (run > max_run) max_run = run;
                if (fed_cnt < lb_limit) begin
                    d = cyc + 2 + (lb_rand ? int'($urandom_range(0, 3)) : 0);
                    if (d <= last_due) d = last_due + 1;
                    due.push_back(d);
                    last_due = d;
                    fed_cnt++;
                end
            end else begin
                run = 0;
            end
            if (pix_we === 1'b1) begin
                chk("write_expected", 64'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    chk("pix_addr", 64'(pix_addr), 64'(w.addr));
                    chk("pix_hit", 64'(pix_hit), 64'(w.hit));
                end
                fwrites++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                chk("busy_low_with_done", 64'(busy), 0);
                chk("busy_high_before_done", 64'(prev_busy), 1);
                chk("writes_at_done", 64'(fwrites), N);
            end
            prev_busy = busy;

            if (ray_valid2 === 1'b1) begin
                chk("d2_screen_x", 64'($unsigned(screen_x2)), 64'(exp_x(r2)));
                chk("d2_screen_y", 64'($unsigned(screen_y2)), 64'(exp_y(r2)));
                r2++;
            end
            if (pix_we2 === 1'b1) begin
                chk("d2_write_expected", 64'(hq2.size() != 0), 1);
                if (hq2.size() != 0) begin
                    hb = hq2.pop_front();
                    chk("d2_pix_addr", 64'(pix_addr2), 64'(w2));
                    chk("d2_pix_hit", 64'(pix_hit2), 64'(hb));
                end
                w2++;
            end
            if (done2 === 1'b1) done2_cnt++;

            if (due.size() != 0 && due[0] == cyc) begin
                void'(due.pop_front());
                hb = 1'($urandom_range(0, 1));
                res_valid = 1'b1;
                res_hit   = hb;
                w.addr = res_idx;
                w.hit  = hb;
                wq.push_back(w);
                res_idx++;
            end else if (inj) begin
                res_valid = 1'b1;
                res_hit   = 1'b1;
            end else begin
                res_valid = 1'b0;
                res_hit   = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        fed_cnt  = 0;
        res_idx  = 0;
        rays_f   = 0;
        fwrites  = 0;
        max_run  = 0;
        last_due = 0;
        for (int p = 0; p < N; p++) begin
            c.x = exp_x(p);
            c.y = exp_y(p);
            cq.push_back(c);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 300) begin
            tick();
            n++;
        end
        chk(nm, 64'(done_cnt - d0), 1);
    endtask

    task automatic frame_end(input string nm);
        chk({nm, "_writes"}, 64'(fwrites), N);
        chk({nm, "_rays_left"}, 64'(cq.size()), 0);
        chk({nm, "_writes_left"}, 64'(wq.size()), 0);
    endtask

    initial begin
        int n;
        int d0;
        rst = 1'b0; start = 1'b0; stall = 1'b0; inj = 1'b0;
        lb_limit = N; lb_rand = 1'b0;
        fed_cnt = 0; res_idx = 0; rays_f = 0; fwrites = 0; done_cnt = 0;
        run = 0; max_run = 0; last_due = 0;
        start2 = 1'b0; stall2 = 1'b0; res_valid2 = 1'b0; res_hit2 = 1'b0;
        r2 = 0; w2 = 0; sent2 = 0; done2_cnt = 0;

        repeat (3) tick();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_ray_valid", 64'(ray_valid), 0);
        chk("rst_pix_we", 64'(pix_we), 0);
        chk("rst_pix_hit", 64'(pix_hit), 0);
        chk("rst_screen_x", 64'($unsigned(screen_x)), 0);
        chk("rst_screen_y", 64'($unsigned(screen_y)), 0);
        chk("rst_pix_addr", 64'(pix_addr), 0);
        chk("rst_d2_busy", 64'(busy2), 0);
        chk("rst_d2_ray_valid", 64'(ray_valid2), 0);
        rst = 1'b1;
        tick();

        // Plain frame with 3-cycle loopback: issue runs unbroken
        start_frame();
        chk("t1_busy_after_start", 64'(busy), 1);
        tick();
        chk("t1_first_ray", 64'(ray_valid), 1);
        chk("t1_first_x", 64'($unsigned(screen_x)), 64'h0000_0000_FFFE_0000);
        wait_done("t1_done");
        chk("t1_consecutive_rays", 64'(max_run), 8);
        frame_end("t1");
        d0 = done_cnt;
        repeat (4) tick();
        chk("t1_single_done", 64'(done_cnt - d0), 0);

        // Stall for 5 cycles right after pixel 1
        start_frame();
        tick();
        tick();
        chk("t2_pixel1_x", 64'($unsigned(screen_x)), 64'h0000_0000_FFFF_0000);
        stall = 1'b1;
        repeat (5) begin
            tick();
            chk("t2_no_ray_in_stall", 64'(ray_valid), 0);
        end
        stall = 1'b0;
        chk("t2_rays_before_release", 64'(rays_f), 2);
        tick();
        chk("t2_resume_ray", 64'(ray_valid), 1);
        chk("t2_resume_x", 64'($unsigned(screen_x)), 0);
        wait_done("t2_done");
        frame_end("t2");

        // start during ISSUE is ignored; results in IDLE are dropped
        start_frame();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6_done");
        frame_end("t6");
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("t6_idle_result_dropped", 64'(pix_we), 0);
        tick();
        chk("t6_idle_stays_idle", 64'(busy), 0);

        // Reset in DRAIN with 3 rays outstanding
        lb_limit = 5;
        start_frame();
        n = 0;
        while (!(rays_f == N && fwrites == 5) && n < 200) begin
            tick();
            n++;
        end
        chk("t5_reached_drain", 64'(rays_f == N && fwrites == 5), 1);
        repeat (2) tick();
        chk("t5_busy_in_drain", 64'(busy), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t5_busy_after_rst", 64'(busy), 0);
        chk("t5_pix_we_after_rst", 64'(pix_we), 0);
        chk("t5_done_after_rst", 64'(done), 0);
        chk("t5_ray_after_rst", 64'(ray_valid), 0);
        inj = 1'b1;
        repeat (3) begin
            tick();
            chk("t5_late_result_dropped", 64'(pix_we), 0);
        end
        inj = 1'b0;
        tick();
        chk("t5_late_no_write", 64'(pix_we), 0);
        chk("t5_late_idle", 64'(busy), 0);
        lb_limit = N;
        start_frame();
        tick();
        chk("t5_restart_x", 64'($unsigned(screen_x)), 64'h0000_0000_FFFE_0000);
        wait_done("t5_restart_done");
        frame_end("t5_restart");

        // Random stalls and random in-order result latency
        lb_rand = 1'b1;
        repeat (3) begin
            start_frame();
            d0 = done_cnt;
            n  = 0;
            while (done_cnt == d0 && n < 500) begin
                stall = ($urandom_range(0, 99) < 40);
                tick();
                n++;
            end
            stall = 1'b0;
            chk("rand_done", 64'(done_cnt - d0), 1);
            frame_end("rand");
        end
        lb_rand = 1'b0;

        // Two credits, nothing returned: exactly two issues
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (10) tick();
        chk("t3_two_issues", 64'(r2), 2);
        res_valid2 = 1'b1;
        res_hit2   = 1'($urandom_range(0, 1));
        hq2.push_back(res_hit2);
        sent2 = 1;
        tick();
        res_valid2 = 1'b0;
        repeat (6) tick();
        chk("t3_one_more_issue", 64'(r2), 3);
        chk("t3_one_write", 64'(w2), 1);

        // Retire at full credits: issue blocked that cycle, resumes next
        chk("t4_saturated", 64'(ray_valid2), 0);
        res_valid2 = 1'b1;
        res_hit2   = 1'($urandom_range(0, 1));
        hq2.push_back(res_hit2);
        sent2 = 2;
        tick();
        res_valid2 = 1'b0;
        chk("t4_issue_blocked", 64'(ray_valid2), 0);
        chk("t4_retire_write", 64'(pix_we2), 1);
        tick();
        chk("t4_issue_resumes", 64'(ray_valid2), 1);
        d0 = done2_cnt;
        n  = 0;
        while (done2_cnt == d0 && n < 200) begin
            if (res_valid2 == 1'b0 && sent2 < r2) begin
                res_valid2 = 1'b1;
                res_hit2   = 1'($urandom_range(0, 1));
                hq2.push_back(res_hit2);
                sent2++;
            end else begin
                res_valid2 = 1'b0;
            end
            tick();
            n++;
        end
        res_valid2 = 1'b0;
        chk("t4_done", 64'(done2_cnt - d0), 1);
        chk("t4_total_rays", 64'(r2), N);
        chk("t4_total_writes", 64'(w2), N);
        chk("t4_writes_left", 64'(hq2.size()), 0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_scheduler.md
Name: pixel_scheduler

Overview:
- Frame-level producer and consumer for the ray pipeline.
- Issues one screen-space coordinate pair per pixel, in raster order, into the ray pipeline's screen_x/screen_y/valid_in input.
- Retires the pipeline's in-order valid_out/hit results. Each result is tagged with its linear pixel address and becomes a framebuffer write.
- A credit counter bounds the number of rays in flight. Frame completion is signalled only after every issued ray has been retired.

Parameters:
- WIDTH, 640, pixels per row (even, ≥2).
- HEIGHT, 480, rows per frame (even, ≥2).
- FP_W, 32, fp word width (signed Q(FP_W-FRAC).FRAC).
- FRAC, 16, fractional bits of fp.
- STEP, 32'h0000_0111, fp coordinate increment per pixel (≈1/240).
- MAX_INFLIGHT, 64, maximum issued-but-unretired rays.
- ADDR_W, $clog2(WIDTH*HEIGHT), pixel address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- start  in  1  begin frame; sampled only in IDLE.
- stall  in  1  1 = suppress issue this cycle (retire continues).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the frame is fully retired.
- ray_valid  out  1  coordinate valid, one pixel per asserted cycle.
- screen_x  out  FP_W  signed fp x coordinate.
- screen_y  out  FP_W  signed fp y coordinate.
- res_valid  in  1  result valid from the ray pipeline, strictly in issue order.
- res_hit  in  1  hit flag for that result.
- pix_we  out  1  framebuffer write strobe.
- pix_addr  out  ADDR_W  linear address y*WIDTH+x of the retired pixel.
- pix_hit  out  1  hit flag to write.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; all counters clear.
  - busy, done, ray_valid, pix_we and pix_hit are 0; screen_x, screen_y and pix_addr are 0.
  - Reset mid-frame abandons the frame. Results arriving after reset are ignored until the next start.
- States:
  - IDLE: on start, load x_cnt=0, y_cnt=0, sx=-(WIDTH/2)*STEP, sy=+(HEIGHT/2)*STEP, retire address=0, credits=0. Go to ISSUE.
  - ISSUE: each cycle, an issue occurs iff !stall && inflight<MAX_INFLIGHT.
    - An issue registers ray_valid=1 with the current sx/sy (outputs are registered, 1-cycle latency from the decision). Otherwise ray_valid=0; sx/sy hold.
    - After an issue: x_cnt++ and sx+=STEP.
    - At x_cnt==WIDTH-1: x_cnt=0, sx reloads to the row start, y_cnt++, sy-=STEP.
    - After the issue of pixel WIDTH*HEIGHT-1, go to DRAIN.
  - DRAIN: no issue. When inflight==0 and retired count==WIDTH*HEIGHT, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
  - start is ignored outside IDLE.
- Coordinate arithmetic:
  - Incremental add/subtract only, no multiplier.
  - Row-start values are computed as constants at elaboration.
  - Two's-complement wrap is allowed; no saturation.
- Retire path (active in ISSUE and DRAIN):
  - res_valid registers pix_we=1, pix_hit=res_hit and pix_addr=retire address (1-cycle latency).
  - The retire address then increments.
  - res_valid in IDLE or DONE is dropped.
- inflight counter:
  - +1 on issue, -1 on retire; a simultaneous issue and retire leaves it unchanged.
  - It never exceeds MAX_INFLIGHT.
  - A retire with inflight==0 is a protocol error: the write is dropped and the counter does not underflow.
- busy is high in ISSUE and DRAIN.
- stall has no effect in DRAIN.

Test Plan:
1. WIDTH=4, HEIGHT=2, STEP=0x00010000; start, stall=0, results looped back with 3-cycle delay.
   - ray_valid asserts on 8 consecutive cycles.
   - screen_x sequence is FFFE0000, FFFF0000, 00000000, 00010000, then repeats for row 1.
   - screen_y is 00010000 for row 0 and 00000000 for row 1.
   - pix_addr 0..7 are written in order; done pulses once after the 8th retire; busy falls with done.
2. stall held high for 5 cycles mid-row 0 after pixel 1 → no ray_valid during the stall; the next issued screen_x is 00000000 (pixel 2); the frame completes with 8 writes.
3. MAX_INFLIGHT=2, no results returned → exactly 2 issues, then ray_valid stays 0. Returning one result → exactly one further issue.
4. Issue and retire in the same cycle with inflight=2 at MAX_INFLIGHT=2 → inflight stays 2 and the issue is blocked that cycle. Next cycle: inflight=1 and issue resumes.
5. rst=0 pulsed during DRAIN with 3 rays outstanding → next cycle busy=0, pix_we=0, done=0. Late res_valid is ignored. A following start restarts at pix_addr 0 with screen_x FFFE0000.
6. start pulsed during ISSUE, and res_valid with hit=1 injected in IDLE → no restart and no pix_we; the frame still totals 8 writes.
